// File: rtl/logic_gate_pipe.sv
// Registered bitwise logic stage: eight selectable operations, one output register
// with valid/ready handshake, reduction flags and a saturating all-ones result counter.
module logic_gate_pipe #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic              y_all,
  output logic              y_any,
  output logic [2:0]        op_out,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  hit_cnt
);

  logic [DATA_W-1:0] res;
  logic              accept;
  logic              xfer;

  always_comb begin
    res = '0;
    case (op_sel)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: res = a ^ b;
      3'd3: res = ~(a & b);
      3'd4: res = ~(a | b);
      3'd5: res = ~(a ^ b);
      3'd6: res = ~a;
      3'd7: res = a;
      default: res = '0;
    endcase
  end

  // A held result frees the stage in the same cycle it is taken downstream.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      y_all     <= 1'b0;
      y_any     <= 1'b0;
      op_out    <= 3'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= res;
      y_all     <= &res;
      y_any     <= |res;
      op_out    <= op_sel;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Counts results actually delivered, so a stalled result is counted once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hit_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt <= '0;
    end else if (xfer && y_all && (hit_cnt != {CNT_W{1'b1}})) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
Parametrised, registered successor to the team's single-bit two-input gate. Applies one of eight bitwise logic operations, chosen per transaction, to two DATA_W-bit operands. The result passes through one output register stage with valid/ready flow control. The block also provides reduction flags and a saturating counter of all-ones results, so it drops into the board demo and LED-display designs as a reusable logic stage.

Parameters:
DATA_W, 8, operand/result width in bits (1..64)
CNT_W, 16, width of the all-ones result counter (2..32)

Ports:
sys_clk  input  1  system clock; all state updates on its rising edge
sys_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands this cycle
op_sel  input  3  operation select, sampled with operands
a  input  DATA_W  operand A
b  input  DATA_W  operand B
out_valid  output  1  y/flags/op_out hold a valid result
out_ready  input  1  downstream accepts result this cycle
y  output  DATA_W  registered result
y_all  output  1  reduction AND of y
y_any  output  1  reduction OR of y
op_out  output  3  op_sel that produced y
cnt_clr  input  1  synchronous clear of hit_cnt
hit_cnt  output  CNT_W  count of delivered results with y all ones, saturating

Behaviour:
- Reset (sys_rst_n low, asynchronous assert, release synchronised externally): out_valid=0, y=0, y_all=0, y_any=0, op_out=0, hit_cnt=0. in_ready is combinational and reads 1 while out_valid=0.
- Operations, bitwise over DATA_W bits: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a (b ignored), 7 pass a (b ignored).
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Input accept: in_valid && in_ready. On an accept, the next edge loads y, y_all, y_any and op_out, and sets out_valid=1. Latency is one cycle from accept to out_valid.
- Output transfer: out_valid && out_ready.
  - Transfer with a simultaneous accept: registers reload and out_valid stays 1. This gives full throughput of one result per cycle.
  - Transfer with no accept: out_valid goes to 0. y and the flags hold their old values (don't-care).
- Backpressure: while out_valid=1 and out_ready=0, y, y_all, y_any and op_out are held stable and in_ready=0. Operands on the inputs are not consumed.
- y_all and y_any are registered together with y and always describe the current y. For DATA_W=1, y_all = y_any = y.
- hit_cnt increments by 1 on each output transfer where y_all=1. It saturates at 2^CNT_W-1 and does not wrap.
- cnt_clr=1 zeroes hit_cnt on the next edge and takes priority over a simultaneous increment.
- in_valid low, or out_ready toggling while out_valid=0, has no effect on state.
- Reset mid-transaction discards any held result immediately. No partial output appears after reset release.
- No combinational path from in_valid, a, b or op_sel to any output. The only combinational path is out_ready -> in_ready.

Test Plan:
- Reset, then DATA_W=8, out_ready=1, a=8'hF0, b=8'h3C, op_sel stepped 0..7 on consecutive cycles -> y = 30, FC, CC, CF, 03, 33, 0F, F0 on the following cycles. out_valid stays 1 throughout and op_out matches each op_sel.
- Backpressure: hold out_ready=0 after one accept of a=8'hAA, b=8'h55, op=1 -> y=FF, y_all=1, y_any=1 held for 5 cycles with in_ready=0. A new operand presented meanwhile is not taken. Releasing out_ready -> one transfer, then the next operand is accepted in the same cycle.
- Reduction flags: op 0 with a=8'h0F, b=8'hF0 -> y=00, y_all=0, y_any=0. Op 4 with a=0, b=0 -> y=FF, y_all=1, y_any=1.
- Counter: CNT_W=2, four transfers of y=FF -> hit_cnt 1, 2, 3, 3 (saturated). Assert cnt_clr in the same cycle as a fifth all-ones transfer -> hit_cnt=0.
- Reset mid-stream: assert sys_rst_n low asynchronously while out_valid=1 and out_ready=0 -> out_valid, y and hit_cnt read 0 before the next clock edge, and in_ready=1.
- DATA_W=1 build: exhaustive a/b/op_sel sweep with random out_ready -> every delivered y matches the truth table in order, with no loss or duplication.
